// File: rtl/bank_access_scheduler.sv
// bank_access_scheduler: per-frame write/read sequencer sharing one memory port across banks, with saturated read mix.
// Optional access timeout enabled by defining SCHED_TIMEOUT_EN.
module bank_access_scheduler #(
    parameter int NUM_BANKS = 8,
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 24
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  frame_pulse,
    input  logic [NUM_BANKS-1:0]                  record_mask,
    input  logic [NUM_BANKS-1:0]                  play_mask,
    input  logic [DATA_W-1:0]                     rec_sample,
    output logic                                  mem_req,
    output logic                                  mem_we,
    output logic [$clog2(NUM_BANKS)+ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]                     mem_wdata,
    input  logic                                  mem_ack,
    input  logic                                  mem_rvalid,
    input  logic [DATA_W-1:0]                     mem_rdata,
    output logic [DATA_W-1:0]                     mix_out,
    output logic                                  mix_valid,
    output logic [ADDR_W-1:0]                     block_addr,
    output logic                                  overrun,
    output logic                                  mem_timeout
);
    localparam int BW = $clog2(NUM_BANKS);
    localparam int AW = DATA_W + BW;
    localparam logic signed [AW-1:0] MAX = {{(BW+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN = {{(BW+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, WRITE, READ, READ_WAIT, FINISH} state_t;

    state_t                state, state_n;
    logic [NUM_BANKS-1:0]  rec_pend, ply_pend, rec_n, ply_n, sel, sel_1h;
    logic [BW-1:0]         bank;
    logic signed [AW-1:0]  acc, acc_n, ext;
    logic [DATA_W-1:0]     sat;
    logic                  any_act, tmo, fin_n;

    assign sel     = (state == WRITE) ? rec_pend : ply_pend;
    assign sel_1h  = sel & -sel;
    assign mem_req = (state == WRITE) || (state == READ);
    assign mem_we  = (state == WRITE);
    assign mem_addr = {bank, block_addr};
    assign ext     = {{BW{mem_rdata[DATA_W-1]}}, mem_rdata};
    assign sat     = acc_n > MAX ? {1'b0, {(DATA_W-1){1'b1}}} :
                     acc_n < MIN ? {1'b1, {(DATA_W-1){1'b0}}} : acc_n[DATA_W-1:0];
    assign fin_n   = (state_n == FINISH) && (state != FINISH);

    always_comb begin
        bank = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--)
            if (sel[i]) bank = BW'(i);
    end

`ifdef SCHED_TIMEOUT_EN
    logic [7:0] tcnt;
    logic       busy, prog;
    assign busy = (state == WRITE) || (state == READ) || (state == READ_WAIT);
    assign prog = (mem_req && mem_ack) || (state == READ_WAIT && mem_rvalid);
    assign tmo  = busy && !prog && (tcnt == 8'd254);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt        <= '0;
            mem_timeout <= 1'b0;
        end else begin
            tcnt        <= (!busy || prog || tmo) ? 8'd0 : tcnt + 8'd1;
            mem_timeout <= mem_timeout || tmo;
        end
    end
`else
    assign tmo         = 1'b0;
    assign mem_timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        rec_n   = rec_pend;
        ply_n   = ply_pend;
        acc_n   = acc;
        case (state)
            IDLE: if (frame_pulse) begin
                rec_n   = record_mask;
                ply_n   = play_mask;
                acc_n   = '0;
                state_n = |record_mask ? WRITE : |play_mask ? READ : FINISH;
            end
            WRITE: if (mem_ack || tmo) begin
                rec_n   = rec_pend & ~sel_1h;
                state_n = |rec_n ? WRITE : |ply_pend ? READ : FINISH;
            end
            // a timed-out read skips READ_WAIT and contributes nothing
            READ: if (mem_ack || tmo) begin
                ply_n   = ply_pend & ~sel_1h;
                state_n = mem_ack ? READ_WAIT : |ply_n ? READ : FINISH;
            end
            READ_WAIT: if (mem_rvalid || tmo) begin
                acc_n   = acc + (mem_rvalid ? ext : '0);
                state_n = |ply_pend ? READ : FINISH;
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rec_pend   <= '0;
            ply_pend   <= '0;
            acc        <= '0;
            any_act    <= 1'b0;
            mem_wdata  <= '0;
            mix_out    <= '0;
            mix_valid  <= 1'b0;
            block_addr <= '0;
            overrun    <= 1'b0;
        end else begin
            state     <= state_n;
            rec_pend  <= rec_n;
            ply_pend  <= ply_n;
            acc       <= acc_n;
            overrun   <= frame_pulse && (state != IDLE);
            mix_valid <= fin_n;
            if (state == IDLE && frame_pulse) begin
                any_act   <= |record_mask || |play_mask;
                mem_wdata <= rec_sample;
            end
            if (fin_n) mix_out <= sat;
            if (state == FINISH) block_addr <= any_act ? block_addr + ADDR_W'(1) : '0;
        end
    end
endmodule
